aac_adts_frame_sequencer: RTL and testbench

Front-end controller for the AAC decoder core. It hunts for the ADTS syncword in the incoming byte stream and parses and validates the header. It then hands a configuration word to the core, streams exactly the frame's payload bytes to it, and waits for the core's frame-done before accepting the next frame. All core sequencing is done here: frame delimiting, config handoff, done/timeout supervision, and error counting.

---
 rtl/aac_dec_pkg.sv | 39 +++
 rtl/aac_adts_hdr_capture.sv | 39 +++
 rtl/aac_adts_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_aac_adts_frame_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aac_dec_pkg.sv
// Shared types and ADTS constants for the AAC decoder front end.
// This file has no logic, so latency and backpressure do not apply.
package aac_dec_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC2,
    ST_HDR,
    ST_CRC,
    ST_CHECK,
    ST_CFG,
    ST_PAYLOAD,
    ST_WAIT_DONE
  } seq_state_t;

  localparam logic [7:0] ADTS_SYNC_HI = 8'hFF;
  localparam int         ADTS_HDR_LEN = 7;
  localparam int         ADTS_CRC_LEN = 2;

  typedef logic [12:0] frame_len_t;

  typedef struct packed {
    logic [1:0] profile;
    logic [3:0] sf_idx;
    logic [2:0] chan;
    logic [1:0] nblk;
  } adts_cfg_t;

  // Second syncword byte: upper nibble all ones, layer bits zero.
  function automatic logic is_sync_lo(input logic [7:0] b);
    return (b[7:4] == 4'hF) && (b[2:1] == 2'b00);
  endfunction

  function automatic frame_len_t hdr_len_of(input logic prot_absent);
    return prot_absent ? frame_len_t'(ADTS_HDR_LEN)
                       : frame_len_t'(ADTS_HDR_LEN + ADTS_CRC_LEN);
  endfunction

endpackage

// File: rtl/aac_adts_hdr_capture.sv
// Latches ADTS header fields from header bytes 2..6, indexed by byte position.
// Fields update on the clock edge that accepts each header byte; it never stalls.
module aac_adts_hdr_capture
  import aac_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_en,
  input  logic [2:0] byte_idx,
  input  logic [7:0] byte_dat,
  output adts_cfg_t  cfg,
  output frame_len_t frame_len
);

  // byte_idx 0 holds header byte 2. frame_length spans header bytes 3 to 5.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg       <= '0;
      frame_len <= '0;
    end else if (cap_en) begin
      case (byte_idx)
        3'd0: begin
          cfg.profile <= byte_dat[7:6];
          cfg.sf_idx  <= byte_dat[5:2];
          cfg.chan[2] <= byte_dat[0];
        end
        3'd1: begin
          cfg.chan[1:0]    <= byte_dat[7:6];
          frame_len[12:11] <= byte_dat[1:0];
        end
        3'd2: frame_len[10:3] <= byte_dat;
        3'd3: frame_len[2:0]  <= byte_dat[7:5];
        3'd4: cfg.nblk        <= byte_dat[1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/aac_adts_frame_sequencer.sv
// Finds the ADTS sync, checks the header, hands config to the core, streams the payload and waits for done.
// Payload passes through combinationally with zero latency, and in_ready follows out_ready. Header bytes are always accepted.
module aac_adts_frame_sequencer
  import aac_dec_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 65535,
  parameter int MAX_SF_IDX = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [1:0]       cfg_profile,
  output logic [3:0]       cfg_sf_idx,
  output logic [2:0]       cfg_chan,
  output logic [1:0]       cfg_nblk,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  input  logic             core_done,
  output logic             busy,
  output logic             err_pulse,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);
  localparam logic [3:0] SF_MAX = 4'(MAX_SF_IDX);

  seq_state_t       state, state_nxt;
  logic [2:0]       byte_cnt;
  logic             prot_absent;
  frame_len_t       payload_rem;
  frame_len_t       hdr_len;
  frame_len_t       frame_len;
  adts_cfg_t        hdr_cfg;
  logic [TMR_W-1:0] timer;
  logic             fire;
  logic             hdr_ok;
  logic             last_hdr_byte;
  logic             last_crc_byte;
  logic             timeout_hit;

  assign fire          = in_valid & in_ready;
  assign hdr_len       = hdr_len_of(prot_absent);
  assign hdr_ok        = (frame_len > hdr_len) && (hdr_cfg.sf_idx <= SF_MAX);
  // Header bytes 0 and 1 are the syncword, so the capture sees LEN-2 bytes.
  assign last_hdr_byte = (byte_cnt == 3'(ADTS_HDR_LEN - 3));
  assign last_crc_byte = (byte_cnt == 3'(ADTS_CRC_LEN - 1));
  assign timeout_hit   = (TIMEOUT != 0) && (timer == TMR_LAST);

  aac_adts_hdr_capture u_hdr_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_en    ((state == ST_HDR) && fire),
    .byte_idx  (byte_cnt),
    .byte_dat  (in_data),
    .cfg       (hdr_cfg),
    .frame_len (frame_len)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT: begin
        if (fire && (in_data == ADTS_SYNC_HI)) state_nxt = ST_SYNC2;
      end
      ST_SYNC2: begin
        if (fire) begin
          if (is_sync_lo(in_data))           state_nxt = ST_HDR;
          else if (in_data != ADTS_SYNC_HI)  state_nxt = ST_HUNT;
        end
      end
      ST_HDR: begin
        if (fire && last_hdr_byte) state_nxt = prot_absent ? ST_CHECK : ST_CRC;
      end
      ST_CRC: begin
        if (fire && last_crc_byte) state_nxt = ST_CHECK;
      end
      ST_CHECK:   state_nxt = hdr_ok ? ST_CFG : ST_HUNT;
      ST_CFG: begin
        if (cfg_ready) state_nxt = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (fire && (payload_rem == 13'd1)) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (core_done || timeout_hit) state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_HUNT;
    endcase
    if (flush) state_nxt = ST_HUNT;
  end

  always_comb begin
    in_ready  = 1'b0;
    cfg_valid = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    err_pulse = 1'b0;
    case (state)
      ST_HUNT, ST_SYNC2, ST_HDR, ST_CRC: in_ready = 1'b1;
      ST_CHECK:     err_pulse = !hdr_ok && !flush;
      ST_CFG:       cfg_valid = 1'b1;
      ST_PAYLOAD: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        out_data  = in_data;
        out_last  = (payload_rem == 13'd1);
      end
      // A done arriving on the timeout cycle wins, and the frame counts as completed.
      ST_WAIT_DONE: err_pulse = timeout_hit && !core_done && !flush;
      default: ;
    endcase
  end

  assign busy        = (state != ST_HUNT);
  assign cfg_profile = hdr_cfg.profile;
  assign cfg_sf_idx  = hdr_cfg.sf_idx;
  assign cfg_chan    = hdr_cfg.chan;
  assign cfg_nblk    = hdr_cfg.nblk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      prot_absent <= 1'b0;
      payload_rem <= '0;
      timer       <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if ((state == ST_SYNC2) && fire && is_sync_lo(in_data)) prot_absent <= in_data[0];

      if (flush || (state_nxt != state))                       byte_cnt <= '0;
      else if (fire && ((state == ST_HDR) || (state == ST_CRC))) byte_cnt <= byte_cnt + 3'd1;

      if (flush)                                  payload_rem <= '0;
      else if ((state == ST_CHECK) && hdr_ok)     payload_rem <= frame_len - hdr_len;
      else if ((state == ST_PAYLOAD) && fire)     payload_rem <= payload_rem - 13'd1;

      if (flush || (state != ST_WAIT_DONE)) timer <= '0;
      else                                  timer <= timer + TMR_W'(1);

      if ((state == ST_WAIT_DONE) && core_done && !flush && (frame_count != '1))
        frame_count <= frame_count + CNT_W'(1);

      if (err_pulse && (err_count != '1))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aac_adts_frame_sequencer.sv
// Directed bench: stimulus pushes expected config/payload/error events; a negedge monitor pops and compares.
module tb_aac_adts_frame_sequencer;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_profile;
  logic [3:0]       cfg_sf_idx;
  logic [2:0]       cfg_chan;
  logic [1:0]       cfg_nblk;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             core_done;
  logic             busy;
  logic             err_pulse;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_in_cyc = 0;
  int last_ol_cyc = 0;
  bit toggle_rdy  = 1'b0;

  logic [8:0]  exp_pay[$];
  logic [10:0] exp_cfg[$];
  int          exp_err_kind[$];
  int          exp_err_dly[$];

  aac_adts_frame_sequencer #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (16),
    .MAX_SF_IDX (11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_profile (cfg_profile),
    .cfg_sf_idx  (cfg_sf_idx),
    .cfg_chan    (cfg_chan),
    .cfg_nblk    (cfg_nblk),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .core_done   (core_done),
    .busy        (busy),
    .err_pulse   (err_pulse),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_rdy ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000 time units");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    n_tests = n_tests + 1;
    n_fail  = n_fail + 1;
    $display("FAIL %s: got %0h, expected no event", name, got);
  endtask

  // Monitor: every observed handshake or error pulse must match the head of its queue.
  initial begin : monitor
    int k;
    int d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_pulse) begin
          if (exp_err_kind.size() == 0) unexpected("err_pulse", 32'(cyc));
          else begin
            k = exp_err_kind.pop_front();
            d = exp_err_dly.pop_front();
            chk("err_delay", 32'(cyc - (k != 0 ? last_ol_cyc : last_in_cyc)), 32'(d));
          end
        end
        if (cfg_valid && cfg_ready) begin
          if (exp_cfg.size() == 0) unexpected("cfg_handshake", 32'({cfg_profile, cfg_sf_idx, cfg_chan, cfg_nblk}));
          else chk("cfg_word", 32'({cfg_profile, cfg_sf_idx, cfg_chan, cfg_nblk}), 32'(exp_cfg.pop_front()));
        end
        if (out_valid && out_ready) begin
          if (exp_pay.size() == 0) unexpected("payload_byte", 32'({out_last, out_data}));
          else chk("payload_last_data", 32'({out_last, out_data}), 32'(exp_pay.pop_front()));
          if (out_last) last_ol_cyc = cyc;
        end
        if (in_valid && in_ready) last_in_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n = n + 1;
    end
    in_valid = 1'b0;
    if (!ok) unexpected("send_byte_timeout", 32'(b));
  endtask

  task automatic send_hdr(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                          input logic [7:0] b4, input logic [7:0] b5, input logic [7:0] b6);
    send_byte(8'hFF);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    send_byte(b4);
    send_byte(b5);
    send_byte(b6);
  endtask

  task automatic send_payload(input int n, input logic [7:0] base, input int total);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(i);
      exp_pay.push_back({(i == total - 1), b});
      send_byte(b);
    end
  endtask

  task automatic push_err(input int kind, input int dly);
    exp_err_kind.push_back(kind);
    exp_err_dly.push_back(dly);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ctl"}, 32'({in_ready, cfg_valid, out_valid, out_last, err_pulse, busy}), 32'(6'b100000));
    chk({tag, "_frames"}, 32'(frame_count), 32'd0);
    chk({tag, "_errs"}, 32'(err_count), 32'd0);
    chk({tag, "_cfg"}, 32'({cfg_profile, cfg_sf_idx, cfg_chan, cfg_nblk}), 32'd0);
  endtask

  initial begin : stim
    logic [10:0] cfg_std;
    int n;
    cfg_std   = {2'd1, 4'd4, 3'd2, 2'd0};
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    cfg_ready = 1'b1;
    core_done = 1'b0;
    tick(3);
    check_reset_state("reset");
    rst_n = 1'b1;
    tick(1);

    // Basic frame, with config held back for a few cycles.
    cfg_ready = 1'b0;
    exp_cfg.push_back(cfg_std);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    n = 0;
    while (!cfg_valid && n < 10) begin
      tick(1);
      n = n + 1;
    end
    tick(3);
    chk("cfg_hold_valid", 32'(cfg_valid), 32'd1);
    chk("cfg_hold_word", 32'({cfg_profile, cfg_sf_idx, cfg_chan, cfg_nblk}), 32'(cfg_std));
    cfg_ready = 1'b1;
    send_payload(8, 8'h00, 8);
    pulse_done();
    chk("t1_frames", 32'(frame_count), 32'd1);
    chk("t1_errs", 32'(err_count), 32'd0);

    // CRC present: the 2 CRC bytes are dropped and the payload is 6 bytes.
    exp_cfg.push_back(cfg_std);
    send_hdr(8'hF0, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_payload(6, 8'h10, 6);
    pulse_done();
    chk("t2_frames", 32'(frame_count), 32'd2);

    // Garbage ahead of the frame; the second FF is the one that locks.
    exp_cfg.push_back(cfg_std);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'hFF);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    send_payload(8, 8'h20, 8);
    pulse_done();
    chk("t3_frames", 32'(frame_count), 32'd3);
    chk("t3_errs", 32'(err_count), 32'd0);

    // sf_idx 13 is rejected.
    push_err(0, 1);
    send_hdr(8'hF1, 8'h74, 8'h80, 8'h01, 8'hFF, 8'hFC);
    tick(2);
    chk("sf_rej_errs", 32'(err_count), 32'd1);
    chk("sf_rej_idle", 32'({busy, cfg_valid}), 32'd0);
    pulse_done();
    chk("stray_done_frames", 32'(frame_count), 32'd3);

    // frame_length equal to the header length is rejected.
    push_err(0, 1);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h00, 8'hE0, 8'hFC);
    tick(2);
    chk("len_rej_errs", 32'(err_count), 32'd2);

    // sf_idx 11 with a 1-byte payload is accepted, and that single byte is last.
    exp_cfg.push_back({2'd1, 4'd11, 3'd2, 2'd0});
    send_hdr(8'hF1, 8'h6C, 8'h80, 8'h01, 8'h00, 8'hFC);
    send_payload(1, 8'hA5, 1);
    pulse_done();
    chk("min_frames", 32'(frame_count), 32'd4);

    // No core_done arrives, so the frame times out 16 cycles after the last byte.
    exp_cfg.push_back(cfg_std);
    push_err(1, 16);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    send_payload(8, 8'h30, 8);
    n = 0;
    while (busy && n < 40) begin
      tick(1);
      n = n + 1;
    end
    chk("to_errs", 32'(err_count), 32'd3);
    chk("to_frames", 32'(frame_count), 32'd4);
    chk("to_idle", 32'(busy), 32'd0);

    // Flush after the third payload byte while out_ready toggles.
    toggle_rdy = 1'b1;
    exp_cfg.push_back(cfg_std);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    send_payload(3, 8'h40, 8);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_ctl", 32'({busy, out_valid, out_last, cfg_valid}), 32'd0);
    in_data  = 8'h99;
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_hunt_io", 32'({out_valid, in_ready}), 32'(2'b01));
    tick(1);
    in_valid = 1'b0;
    chk("flush_counts", 32'({frame_count, err_count}), 32'({16'd4, 16'd3}));

    exp_cfg.push_back(cfg_std);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    send_payload(8, 8'h50, 8);
    pulse_done();
    chk("post_flush_frames", 32'(frame_count), 32'd5);
    toggle_rdy = 1'b0;
    tick(1);

    // Reset in the middle of a payload.
    exp_cfg.push_back(cfg_std);
    send_hdr(8'hF1, 8'h50, 8'h80, 8'h01, 8'hFF, 8'hFC);
    send_payload(2, 8'h60, 8);
    rst_n = 1'b0;
    tick(1);
    in_data  = 8'h62;
    in_valid = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    tick(1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick(2);

    chk("pay_q_empty", 32'(exp_pay.size()), 32'd0);
    chk("cfg_q_empty", 32'(exp_cfg.size()), 32'd0);
    chk("err_q_empty", 32'(exp_err_kind.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
